// File: rtl/checkbits_monitor.sv
// checkbits_monitor: synchronises/debounces the DV status word and tracks per-group test progress.
// Optional build macro CHECKBITS_SEQ_CHECK_EN enforces in-order group starts and passes on the last group.
`default_nettype none

module checkbits_monitor #(
  parameter int                        WIDTH          = 16,
  parameter int                        NUM_GROUPS     = 3,
  parameter logic [8*NUM_GROUPS-1:0]   GROUP_CODES    = 24'h10_20_40,
  parameter int                        STABLE_CYCLES  = 2,
  parameter int                        TIMEOUT_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      checkbits,
  output logic                  event_valid,
  output logic [15:0]           event_code,
  output logic [2:0]            state,
  output logic                  done,
  output logic [1:0]            err,
  output logic [2:0]            cur_group,
  output logic [NUM_GROUPS-1:0] started_mask,
  output logic [NUM_GROUPS-1:0] passed_mask
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic [3:0]  C_STABLE    = 4'(STABLE_CYCLES);
  localparam logic [23:0] C_WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_hold, r_acc;
  logic [3:0]       r_stab;
  logic             w_same, w_accept, w_upper_ok;
  logic [3:0]       w_stab_next;
  logic [15:0]      w_word;

  // Synchroniser flops survive clear; the stability path and accepted value do not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hold  <= '0;
      r_stab  <= '0;
      r_acc   <= '0;
    end else begin
      r_sync1 <= checkbits;
      r_sync2 <= r_sync1;
      if (clear) begin
        r_hold <= '0;
        r_stab <= '0;
        r_acc  <= '0;
      end else begin
        r_hold <= r_sync2;
        r_stab <= w_stab_next;
        if (w_accept) r_acc <= r_sync2;
      end
    end
  end

  assign w_same      = (r_sync2 == r_hold);
  assign w_stab_next = !w_same ? 4'd0 : ((r_stab == 4'hF) ? 4'hF : r_stab + 4'd1);
  assign w_accept    = w_same && (w_stab_next >= C_STABLE) && (r_sync2 != r_acc);
  assign w_word      = r_sync2[15:0];

  generate
    if (WIDTH > 16) begin : g_upper
      assign w_upper_ok = ~|r_sync2[WIDTH-1:16];
    end else begin : g_no_upper
      assign w_upper_ok = 1'b1;
    end
  endgenerate

  logic                  w_start_hit, w_res_hit;
  logic [2:0]            w_start_g, w_res_g;
  logic [NUM_GROUPS-1:0] w_start_oh, w_res_oh;

  always_comb begin
    w_start_hit = 1'b0;
    w_res_hit   = 1'b0;
    w_start_g   = 3'd0;
    w_res_g     = 3'd0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (w_upper_ok && w_word[15:8] == 8'hA0 && w_word[7:0] == GROUP_CODES[8*g +: 8]) begin
        w_start_hit = 1'b1;
        w_start_g   = 3'(g);
      end
      if (w_upper_ok && w_word[15:8] == 8'hAB && {w_word[7:1], 1'b0} == GROUP_CODES[8*g +: 8]) begin
        w_res_hit = 1'b1;
        w_res_g   = 3'(g);
      end
    end
  end

  assign w_start_oh = NUM_GROUPS'(1) << w_start_g;
  assign w_res_oh   = NUM_GROUPS'(1) << w_res_g;

  state_t                r_state, w_state_n;
  logic [1:0]            r_err, w_err_n;
  logic [2:0]            r_cur, w_cur_n;
  logic [NUM_GROUPS-1:0] r_started, w_started_n, r_passed, w_passed_n;
  logic [23:0]           r_wdog, w_wdog_n;
  logic                  r_evt;
  logic [15:0]           r_code;
  logic                  w_order_bad, w_complete;

`ifdef CHECKBITS_SEQ_CHECK_EN
  logic [3:0] w_pass_cnt;
  always_comb begin
    w_pass_cnt = 4'd0;
    for (int g = 0; g < NUM_GROUPS; g++) w_pass_cnt = w_pass_cnt + 4'(r_passed[g]);
  end
  assign w_order_bad = ({1'b0, w_start_g} != w_pass_cnt);
  assign w_complete  = (w_res_g == 3'(NUM_GROUPS - 1));
`else
  assign w_order_bad = 1'b0;
  assign w_complete  = &w_passed_n;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_err     <= '0;
      r_cur     <= '0;
      r_started <= '0;
      r_passed  <= '0;
      r_wdog    <= '0;
      r_evt     <= 1'b0;
      r_code    <= '0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      r_err     <= '0;
      r_cur     <= '0;
      r_started <= '0;
      r_passed  <= '0;
      r_wdog    <= '0;
      r_evt     <= 1'b0;
      r_code    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_err     <= w_err_n;
      r_cur     <= w_cur_n;
      r_started <= w_started_n;
      r_passed  <= w_passed_n;
      r_wdog    <= w_wdog_n;
      r_evt     <= w_accept;
      if (w_accept) r_code <= w_word;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_err_n     = r_err;
    w_cur_n     = r_cur;
    w_started_n = r_started;
    w_passed_n  = r_passed;
    w_wdog_n    = r_wdog;
    if (r_state == ST_IDLE || r_state == ST_RUNNING) begin
      if (w_accept && w_start_hit) begin
        if (r_state == ST_RUNNING || (r_started & w_start_oh) != '0 || w_order_bad) begin
          w_state_n = ST_FAIL;
          w_err_n   = 2'd3;
        end else begin
          w_started_n = r_started | w_start_oh;
          w_cur_n     = w_start_g;
          w_state_n   = ST_RUNNING;
        end
      end else if (w_accept && w_res_hit) begin
        if (r_state == ST_IDLE || w_res_g != r_cur) begin
          w_state_n = ST_FAIL;
          w_err_n   = 2'd2;
        end else if (!w_word[0]) begin
          w_state_n = ST_FAIL;
          w_err_n   = 2'd1;
        end else begin
          w_passed_n = r_passed | w_res_oh;
          w_state_n  = w_complete ? ST_PASS : ST_IDLE;
        end
      end
      // An event resolving to PASS/FAIL on the expiry cycle takes precedence.
      if (r_wdog == C_WDOG_LAST) begin
        if (w_state_n != ST_PASS && w_state_n != ST_FAIL) begin
          w_state_n = ST_TIMEOUT;
          w_err_n   = 2'd0;
        end
      end else begin
        w_wdog_n = r_wdog + 24'd1;
      end
    end
  end

  assign event_valid  = r_evt;
  assign event_code   = r_code;
  assign state        = r_state;
  assign done         = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
  assign err          = r_err;
  assign cur_group    = r_cur;
  assign started_mask = r_started;
  assign passed_mask  = r_passed;

endmodule

`default_nettype wire
